// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, forwarding
// selects and the multiply/divide engine state.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_DIV  = 3'b110,
        ALU_RSVD = 3'b111
    } aluOp_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwdSel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic isMulDiv(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/exec_iterative_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One step per cycle for WIDTH cycles, then a single DONE cycle.
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    state_e              state;
    logic [CNT_BITS-1:0] cnt;
    logic                isDivQ;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    opB;
    logic [WIDTH-1:0]    hiQ;

    logic [WIDTH:0]      mulSum;
    logic [WIDTH:0]      divShift;
    logic [WIDTH:0]      divDiff;
    logic [WIDTH-1:0]    accNext;
    logic [WIDTH-1:0]    quoNext;

    // acc is the product high word for MUL and the partial remainder for DIV;
    // quo shifts the multiplier out / the quotient bits in.
    always_comb begin
        mulSum   = {1'b0, acc} + {1'b0, (quo[0] ? opB : {WIDTH{1'b0}})};
        divShift = {acc, quo[WIDTH-1]};
        divDiff  = divShift - {1'b0, opB};
        accNext  = '0;
        quoNext  = '0;
        if (isDivQ) begin
            if (divShift >= {1'b0, opB}) begin
                accNext = divDiff[WIDTH-1:0];
                quoNext = {quo[WIDTH-2:0], 1'b1};
            end else begin
                accNext = divShift[WIDTH-1:0];
                quoNext = {quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext = mulSum[WIDTH:1];
            quoNext = {mulSum[0], quo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            isDivQ <= 1'b0;
            acc    <= '0;
            quo    <= '0;
            opB    <= '0;
            hiQ    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        isDivQ <= is_div;
                        acc    <= '0;
                        quo    <= a;
                        opB    <= b;
                    end
                end
                BUSY: begin
                    acc <= accNext;
                    quo <= quoNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_BITS'(WIDTH - 1)) begin
                        state <= DONE;
                        hiQ   <= accNext;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);
    assign lo   = quo;
    assign hi   = hiQ;

endmodule

// File: rtl/exec_iterative.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and
// an iterative multiply/divide engine that stalls the pipeline while running.
module exec_iterative
    import exec_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    readData1,
    input  logic [WIDTH-1:0]    readData2,
    input  logic [WIDTH-1:0]    address,
    input  logic                ctrlAluSrc,
    input  logic [REG_BITS-1:0] rs_IDEX,
    input  logic [REG_BITS-1:0] rt_IDEX,
    input  logic [REG_BITS-1:0] rd_EXMEM,
    input  logic [REG_BITS-1:0] rd_MEMWB,
    input  logic                regWrite_EXMEM,
    input  logic                regWrite_MEMWB,
    input  logic [WIDTH-1:0]    result_EXMEM,
    input  logic [WIDTH-1:0]    valueToWB,
    input  logic [2:0]          aluCtrl,
    input  logic                branch,
    input  logic [WIDTH-1:0]    pcIncr,
    output logic [WIDTH-1:0]    result,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    resultBranch,
    output logic                pcSrc,
    output logic                flushPrevInstr,
    output logic                stall,
    output logic                out_valid
);

    fwdSel_e          fwd1;
    fwdSel_e          fwd2;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] rtVal;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] aluRes;
    logic             zero;
    logic             mdBusy;
    logic             mdDone;
    logic [WIDTH-1:0] mdLo;
    logic [WIDTH-1:0] mdHi;
    logic             idle;
    logic             issue;
    logic             single;

    // EX/MEM has priority over MEM/WB; register 0 never forwards.
    always_comb begin
        fwd1 = FWD_RF;
        if (regWrite_EXMEM && rd_EXMEM != '0 && rd_EXMEM == rs_IDEX)
            fwd1 = FWD_EXMEM;
        else if (regWrite_MEMWB && rd_MEMWB != '0 && rd_MEMWB == rs_IDEX)
            fwd1 = FWD_MEMWB;

        fwd2 = FWD_RF;
        if (regWrite_EXMEM && rd_EXMEM != '0 && rd_EXMEM == rt_IDEX)
            fwd2 = FWD_EXMEM;
        else if (regWrite_MEMWB && rd_MEMWB != '0 && rd_MEMWB == rt_IDEX)
            fwd2 = FWD_MEMWB;
    end

    always_comb begin
        case (fwd1)
            FWD_EXMEM: op1 = result_EXMEM;
            FWD_MEMWB: op1 = valueToWB;
            default:   op1 = readData1;
        endcase
        case (fwd2)
            FWD_EXMEM: rtVal = result_EXMEM;
            FWD_MEMWB: rtVal = valueToWB;
            default:   rtVal = readData2;
        endcase
        op2 = ctrlAluSrc ? address : rtVal;
    end

    always_comb begin
        diff = op1 - op2;
        zero = (diff == '0);
        case (aluCtrl)
            ALU_ADD: aluRes = op1 + op2;
            ALU_SUB: aluRes = diff;
            ALU_AND: aluRes = op1 & op2;
            ALU_OR:  aluRes = op1 | op2;
            ALU_SLT: aluRes = WIDTH'($signed(op1) < $signed(op2));
            default: aluRes = '0;
        endcase
    end

    iter_muldiv #(
        .WIDTH    (WIDTH),
        .CNT_BITS (CNT_BITS)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (issue),
        .is_div (aluCtrl == ALU_DIV),
        .a      (op1),
        .b      (op2),
        .busy   (mdBusy),
        .done   (mdDone),
        .lo     (mdLo),
        .hi     (mdHi)
    );

    assign idle   = !mdBusy && !mdDone;
    assign issue  = idle && in_valid && isMulDiv(aluCtrl);
    assign single = idle && in_valid && !isMulDiv(aluCtrl);

    assign stall          = !reset && (mdBusy || issue);
    assign out_valid      = !reset && (mdDone || single);
    assign pcSrc          = !reset && single && branch && zero;
    assign flushPrevInstr = pcSrc;
    assign result         = reset ? '0 : (mdDone ? mdLo : aluRes);
    assign hi             = mdHi;
    assign resultBranch   = pcIncr + (address << 2);

endmodule

// File: tb/tb_exec_iterative.sv
// Directed bench for exec_iterative: scoreboard queue filled by stimulus,
// drained by a monitor on every out_valid.
module tb_exec_iterative;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] readData1, readData2, address;
    logic         ctrlAluSrc;
    logic [4:0]   rs_IDEX, rt_IDEX, rd_EXMEM, rd_MEMWB;
    logic         regWrite_EXMEM, regWrite_MEMWB;
    logic [W-1:0] result_EXMEM, valueToWB;
    logic [2:0]   aluCtrl;
    logic         branch;
    logic [W-1:0] pcIncr;
    logic [W-1:0] result, hi, resultBranch;
    logic         pcSrc, flushPrevInstr, stall, out_valid;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         chkHi;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    exec_iterative #(.WIDTH(W), .REG_BITS(5), .CNT_BITS(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .readData1(readData1), .readData2(readData2), .address(address),
        .ctrlAluSrc(ctrlAluSrc), .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX),
        .rd_EXMEM(rd_EXMEM), .rd_MEMWB(rd_MEMWB),
        .regWrite_EXMEM(regWrite_EXMEM), .regWrite_MEMWB(regWrite_MEMWB),
        .result_EXMEM(result_EXMEM), .valueToWB(valueToWB),
        .aluCtrl(aluCtrl), .branch(branch), .pcIncr(pcIncr),
        .result(result), .hi(hi), .resultBranch(resultBranch),
        .pcSrc(pcSrc), .flushPrevInstr(flushPrevInstr),
        .stall(stall), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid       = 1'b1;
        aluCtrl        = op;
        readData1      = a;
        readData2      = b;
        address        = '0;
        ctrlAluSrc     = 1'b0;
        rs_IDEX        = 5'd1;
        rt_IDEX        = 5'd2;
        rd_EXMEM       = '0;
        rd_MEMWB       = '0;
        regWrite_EXMEM = 1'b0;
        regWrite_MEMWB = 1'b0;
        result_EXMEM   = '0;
        valueToWB      = '0;
        branch         = 1'b0;
        pcIncr         = '0;
    endtask

    task automatic expectAlu(input logic [W-1:0] exp);
        q.push_back('{lo: exp, hi: '0, chkHi: 1'b0});
    endtask

    // Issues a MUL/DIV and checks stall/out_valid/hi cycle by cycle up to DONE.
    task automatic runMulDiv(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic br, input logic [W-1:0] expLo,
                             input logic [W-1:0] expHi, input logic [W-1:0] prevHi);
        int badCycle;
        setOp(op, a, b);
        branch = br;
        q.push_back('{lo: expLo, hi: expHi, chkHi: 1'b1});
        @(negedge clk);
        chk("issue_stall", W'(stall), W'(1));
        chk("issue_pcSrc", W'(pcSrc), W'(0));
        badCycle = 0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (badCycle == 0 && (stall !== 1'b1 || out_valid !== 1'b0 || hi !== prevHi))
                badCycle = k;
        end
        chk("busy_first_bad_cycle", W'(badCycle), W'(0));
        @(negedge clk);
        chk("done_valid", W'(out_valid), W'(1));
        chk("done_stall", W'(stall), W'(0));
        tick();
    endtask

    // Monitor: every out_valid pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got result %h with empty scoreboard", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.lo);
                    if (e.chkHi) chk("hi", hi, e.hi);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        setOp(3'b000, 32'd1, 32'd2);
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", result, '0);
        chk("rst_hi", hi, '0);
        chk("rst_pcSrc", W'(pcSrc), W'(0));
        aluCtrl = 3'b101;
        #1;
        chk("rst_stall", W'(stall), W'(0));
        tick();
        reset = 1'b0;

        // Forwarding: EX/MEM wins, then MEM/WB, then register 0 bypass.
        setOp(3'b000, 32'd99, 32'd5);
        rs_IDEX = 5'd3; rd_EXMEM = 5'd3; rd_MEMWB = 5'd3;
        regWrite_EXMEM = 1'b1; regWrite_MEMWB = 1'b1;
        result_EXMEM = 32'd10; valueToWB = 32'd20;
        expectAlu(32'd15);
        tick();
        regWrite_EXMEM = 1'b0;
        expectAlu(32'd25);
        tick();
        rs_IDEX = 5'd0; rd_EXMEM = 5'd0; rd_MEMWB = 5'd0; regWrite_EXMEM = 1'b1;
        expectAlu(32'd104);
        tick();
        setOp(3'b001, 32'd99, 32'd5);
        rt_IDEX = 5'd4; rd_MEMWB = 5'd4; regWrite_MEMWB = 1'b1; valueToWB = 32'd20;
        expectAlu(32'd79);
        tick();
        ctrlAluSrc = 1'b1; address = 32'd9;
        expectAlu(32'd90);
        tick();

        setOp(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00);
        expectAlu(32'h00F0_1200);
        tick();
        setOp(3'b011, 32'hF0F0_1234, 32'h0FF0_FF00);
        expectAlu(32'hFFF0_FF34);
        tick();
        setOp(3'b100, 32'hFFFF_FFFF, 32'd1);
        expectAlu(32'd1);
        tick();
        setOp(3'b100, 32'd1, 32'hFFFF_FFFF);
        expectAlu(32'd0);
        tick();
        setOp(3'b111, 32'd7, 32'd3);
        expectAlu(32'd0);
        tick();
        setOp(3'b000, 32'hFFFF_FFFF, 32'd2);
        expectAlu(32'd1);
        tick();

        // Branch taken / not taken.
        setOp(3'b001, 32'h40, 32'h40);
        branch = 1'b1; pcIncr = 32'h100; address = 32'd4;
        expectAlu(32'd0);
        @(negedge clk);
        chk("br_pcSrc", W'(pcSrc), W'(1));
        chk("br_flush", W'(flushPrevInstr), W'(1));
        chk("br_target", resultBranch, 32'h110);
        tick();
        readData2 = 32'h41;
        expectAlu(32'hFFFF_FFFF);
        @(negedge clk);
        chk("br_not_taken", W'(pcSrc), W'(0));
        chk("br_no_flush", W'(flushPrevInstr), W'(0));
        tick();

        // Back-to-back multi-cycle ops; hi must only move at each DONE.
        runMulDiv(3'b101, 32'd7, 32'd6, 1'b0, 32'd42, 32'd0, 32'd0);
        runMulDiv(3'b101, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFE, 32'd1, 32'd0);
        runMulDiv(3'b110, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32'd1);
        runMulDiv(3'b110, 32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd9, 32'd2);
        setOp(3'b000, 32'd3, 32'd4);
        expectAlu(32'd7);
        @(negedge clk);
        chk("hi_hold_single", hi, 32'd9);
        tick();
        runMulDiv(3'b101, 32'd5, 32'd5, 1'b1, 32'd25, 32'd0, 32'd9);

        // Abort a MUL at BUSY cycle 10.
        setOp(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("abort_issue_stall", W'(stall), W'(1));
        for (int k = 1; k <= 10; k++) @(negedge clk);
        chk("abort_busy_stall", W'(stall), W'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_stall", W'(stall), W'(0));
        chk("abort_rst_valid", W'(out_valid), W'(0));
        tick();
        reset = 1'b0;
        setOp(3'b000, 32'd2, 32'd3);
        expectAlu(32'd5);
        @(negedge clk);
        chk("abort_idle_stall", W'(stall), W'(0));
        chk("abort_hi_cleared", hi, '0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) @(negedge clk);
        chk("scoreboard_drained", W'(q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
